mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LINES, default 256, number of 128-bit lines stored (power of two, 2..4096).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from request acceptance to mem_ready (1..255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  sole clock, all state changes on rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: mem_read  input  1  cache read request, held high until mem_ready seen.
REQ-007 SHALL have port: mem_write  input  1  cache write request, held high until mem_ready seen.
REQ-008 SHALL have port: mem_addr  input  [31:4]  line address.
REQ-009 SHALL have port: mem_wdata  input  128  write line data.
REQ-010 SHALL have port: mem_rdata  output  128  read line data, registered.
REQ-011 SHALL have port: mem_ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: proto_err  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE: at an edge with mem_read or mem_write high, SHALL latch addr, wdata, op into request registers, load counter with LATENCY-1, go to WAIT.
REQ-015 WAIT: counter decrements each edge; at the edge where counter is 0, SHALL go to DONE, set mem_ready=1 and perform the access.
REQ-016 Timing: acceptance at edge E0, mem_ready high from E0+LATENCY to E0+LATENCY+1, exactly one cycle.
REQ-017 DONE: SHALL go to IDLE unconditionally at the next edge, clear mem_ready; earliest next acceptance is E0+LATENCY+2.
REQ-018 Write: line index = latched addr[log2(DEPTH_LINES)+3:4]; array written at the same edge mem_ready rises.
REQ-019 Read: mem_rdata loaded from the array at the same edge mem_ready rises; held unchanged until the next read completion (writes leave it unchanged).
REQ-020 Read and write both high at acceptance: SHALL service as write, set proto_err.
REQ-021 Latched address bits above the index nonzero: SHALL wrap (use index bits only), set proto_err.
REQ-022 During WAIT, request dropped or addr/op changed vs latched values: SHALL complete the latched access unchanged, set proto_err.
REQ-023 Request high during DONE: SHALL be ignored (not accepted).
REQ-024 proto_err SHALL remain 1 until rst.
REQ-025 Read after write to the same line SHALL return the written data (no bypass hazard: write commits before next acceptance).

Reset
REQ-026 rst high at an edge SHALL force IDLE, mem_ready=0, mem_rdata=0, proto_err=0, counter=0, request registers=0.
REQ-027 Reset mid-WAIT SHALL abort the access with no array write and no mem_ready pulse.
REQ-028 Array contents SHALL NOT be reset and SHALL survive rst.
REQ-029 rst has priority over every simultaneous event.

Structure
REQ-030 Shared package mem_resp_pkg SHALL hold: state enum (IDLE/WAIT/DONE), LINE_W=128, ADDR_HI=31, ADDR_LO=4.
REQ-031 Line storage SHALL be one sub-module mem_line_ram: single-port, synchronous write, synchronous read, DEPTH_LINES x 128.
REQ-032 Counter width SHALL be 8 bits.

Verification
REQ-033 LATENCY=4: write addr 0x0000010, wdata 0xDEADBEEF_..._01 at E0 -> mem_ready only at E4, proto_err=0.
REQ-034 Then read addr 0x0000010 at E6 -> mem_ready only at E10, mem_rdata=0xDEADBEEF_..._01 from E10 and held after.
REQ-035 LATENCY=1: back-to-back reads lines 1, 2 held high -> ready at E1 and E4, no acceptance during DONE, correct data each.
REQ-036 Read and write both high, addr 0x0000003 -> serviced as write, proto_err=1, sticky until rst.
REQ-037 DEPTH_LINES=256, write addr 0x0000105 -> line 0x05 written, proto_err=1; read 0x0000005 returns that data.
REQ-038 rst pulse at E2 of LATENCY=4 write -> no mem_ready, target line unchanged, outputs zero, prior array data intact.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder and its line store.
package mem_resp_pkg;
  localparam int LINE_W  = 128;
  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mem_line_ram.sv
// Single-port line store: synchronous write, synchronous registered read.
// The array itself is never reset; only the read register is.
module mem_line_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_q;

  // Array write; kept free of reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (en && we) mem[idx] <= wdata;
  end

  // Read register loads only on a read access and otherwise holds its value.
  always_ff @(posedge clk) begin
    if (rst)             rdata_q <= '0;
    else if (en && !we)  rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line memory responder with protocol-error monitoring.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_HI:ADDR_LO] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  proto_err
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_HI:ADDR_LO]   addr_q, addr_d;
  logic [LINE_W-1:0]        wdata_q, wdata_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic                     ready_q, ready_d;
  logic                     perr_q, perr_d;
  logic                     access;
  logic                     hi_nz;

  // Address bits above the line index would alias; flag them at acceptance.
  assign hi_nz = (mem_addr >> IDX_W) != '0;

  // Next-state: accept in IDLE, count down in WAIT, single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    perr_d  = perr_q;
    ready_d = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = WAIT;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = CNT_LOAD;
          if ((mem_read && mem_write) || hi_nz) perr_d = 1'b1;
        end
      end
      WAIT: begin
        // Requester must hold the same request; the latched one completes regardless.
        if (mem_read != rd_q || mem_write != wr_q || mem_addr != addr_q) perr_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          ready_d = 1'b1;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      perr_q  <= perr_d;
    end
  end

  // Both-high requests are serviced as writes, so wr_q alone selects the op.
  mem_line_ram #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (access && !rst),
    .we    (wr_q),
    .idx   (addr_q[ADDR_LO+IDX_W-1:ADDR_LO]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign mem_ready = ready_q;
  assign proto_err = perr_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=4 and LATENCY=1 instances.
module tb_mem_responder;
  logic         clk = 1'b0;
  logic         rst;
  logic         r4, w4, r1, w1;
  logic [27:0]  a4, a1;
  logic [127:0] d4, d1;
  logic [127:0] rdata4, rdata1;
  logic         rdy4, rdy1, perr4, perr1;
  int           n_cmp = 0;
  int           n_err = 0;

  localparam logic [127:0] W1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] W2 = 128'h22222222_33333333_44444444_55555555;
  localparam logic [127:0] W3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] W4 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] W5 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] W6 = 128'h66666666_00000000_66666666_00000006;
  localparam logic [127:0] L1 = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] L2 = 128'h22220000_22220000_22220000_22220002;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LINES(256), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .mem_read(r4), .mem_write(w4), .mem_addr(a4),
    .mem_wdata(d4), .mem_rdata(rdata4), .mem_ready(rdy4), .proto_err(perr4)
  );

  mem_responder #(.DEPTH_LINES(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(r1), .mem_write(w1), .mem_addr(a1),
    .mem_wdata(d1), .mem_rdata(rdata1), .mem_ready(rdy1), .proto_err(perr1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LATENCY=4 transaction: request held until ready, checked at each edge E0..E5.
  task automatic xact4(input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] d, input string tag);
    r4 = rd; w4 = wr; a4 = a; d4 = d;
    for (int c = 0; c <= 4; c++) begin
      tick();
      chk({tag, "_rdy"}, 128'(rdy4), 128'(c == 4));
    end
    r4 = 1'b0; w4 = 1'b0;
    tick();
    chk({tag, "_rdy_clr"}, 128'(rdy4), 128'(0));
  endtask

  // LATENCY=1 transaction: ready one edge after acceptance.
  task automatic xact1(input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] d, input string tag);
    r1 = rd; w1 = wr; a1 = a; d1 = d;
    tick();
    chk({tag, "_rdy0"}, 128'(rdy1), 128'(0));
    tick();
    chk({tag, "_rdy1"}, 128'(rdy1), 128'(1));
    r1 = 1'b0; w1 = 1'b0;
    tick();
    chk({tag, "_rdy_clr"}, 128'(rdy1), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    r4 = 0; w4 = 0; a4 = '0; d4 = '0;
    r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", 128'(rdy4), 128'(0));
    chk("rst_rdata", rdata4, 128'(0));
    chk("rst_perr", 128'(perr4), 128'(0));

    // Plain write then read of line 0x10; ready exactly at E4 / E10.
    xact4(1'b0, 1'b1, 28'h0000010, W1, "wr10");
    chk("wr10_perr", 128'(perr4), 128'(0));
    chk("wr10_rdata_untouched", rdata4, 128'(0));
    xact4(1'b1, 1'b0, 28'h0000010, '0, "rd10");
    chk("rd10_data", rdata4, W1);
    tick(); tick();
    chk("rd10_held", rdata4, W1);

    // Write to another line leaves rdata unchanged.
    xact4(1'b0, 1'b1, 28'h0000020, W2, "wr20");
    chk("wr20_rdata_held", rdata4, W1);
    chk("wr20_perr", 128'(perr4), 128'(0));

    // Both high: serviced as write, sticky error.
    xact4(1'b1, 1'b1, 28'h0000003, W3, "both");
    chk("both_perr", 128'(perr4), 128'(1));
    xact4(1'b1, 1'b0, 28'h0000003, '0, "rd03");
    chk("rd03_data", rdata4, W3);
    tick(); tick();
    chk("both_perr_sticky", 128'(perr4), 128'(1));

    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_perr", 128'(perr4), 128'(0));
    chk("rst2_rdata", rdata4, 128'(0));

    // Address above index wraps onto line 0x05.
    xact4(1'b0, 1'b1, 28'h0000105, W4, "wrap");
    chk("wrap_perr", 128'(perr4), 128'(1));
    xact4(1'b1, 1'b0, 28'h0000005, '0, "rd05");
    chk("rd05_data", rdata4, W4);

    rst = 1'b1; tick(); rst = 1'b0;

    // Reset at E2 aborts a write to line 0x10.
    r4 = 1'b0; w4 = 1'b1; a4 = 28'h0000010; d4 = W5;
    tick();
    tick();
    rst = 1'b1; w4 = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("abort_rdy", 128'(rdy4), 128'(0));
      tick();
    end
    chk("abort_perr", 128'(perr4), 128'(0));
    chk("abort_rdata", rdata4, 128'(0));
    xact4(1'b1, 1'b0, 28'h0000010, '0, "rd10b");
    chk("abort_line_intact", rdata4, W1);
    xact4(1'b1, 1'b0, 28'h0000020, '0, "rd20");
    chk("rd20_survives_rst", rdata4, W2);
    xact4(1'b1, 1'b0, 28'h0000005, '0, "rd05b");
    chk("rd05_survives_rst", rdata4, W4);
    chk("clean_perr", 128'(perr4), 128'(0));

    // Address changed mid-WAIT: latched access completes, error flagged.
    r4 = 1'b0; w4 = 1'b1; a4 = 28'h0000030; d4 = W6;
    tick();
    a4 = 28'h0000031;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("chg_rdy", 128'(rdy4), 128'(c == 4));
    end
    w4 = 1'b0;
    chk("chg_perr", 128'(perr4), 128'(1));
    tick();
    xact4(1'b1, 1'b0, 28'h0000030, '0, "rd30");
    chk("rd30_latched_write", rdata4, W6);

    // LATENCY=1: fill lines 1 and 2, then back-to-back held reads.
    xact1(1'b0, 1'b1, 28'h0000001, L1, "l1_wr1");
    xact1(1'b0, 1'b1, 28'h0000002, L2, "l1_wr2");
    r1 = 1'b1; a1 = 28'h0000001;
    tick();                                           // E0 accept
    chk("l1_e0_rdy", 128'(rdy1), 128'(0));
    tick();                                           // E1 ready
    chk("l1_e1_rdy", 128'(rdy1), 128'(1));
    chk("l1_e1_data", rdata1, L1);
    a1 = 28'h0000002;
    tick();                                           // E2 DONE, not accepted
    chk("l1_e2_rdy", 128'(rdy1), 128'(0));
    chk("l1_e2_hold", rdata1, L1);
    tick();                                           // E3 accept
    chk("l1_e3_rdy", 128'(rdy1), 128'(0));
    tick();                                           // E4 ready
    chk("l1_e4_rdy", 128'(rdy1), 128'(1));
    chk("l1_e4_data", rdata1, L2);
    r1 = 1'b0;
    tick();
    chk("l1_e5_rdy", 128'(rdy1), 128'(0));
    chk("l1_perr", 128'(perr1), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
